// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Purpose  : Stepped frequency sweep sequencer driving a DDS frequency/phase
//            word, with per-step dwell, optional looping and abort.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int PW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_f0,
    input  logic [PW-1:0] cfg_step,
    input  logic [CW-1:0] cfg_nsteps,
    input  logic [CW-1:0] cfg_dwell,
    input  logic [PW-1:0] cfg_phase,
    input  logic          cfg_loop,
    input  logic          abort,
    output logic          dds_en,
    output logic [PW-1:0] dds_freq,
    output logic [PW-1:0] dds_phase,
    output logic [CW-1:0] step_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_f0;
    logic [PW-1:0] r_step;
    logic [CW-1:0] r_nsteps;
    logic [CW-1:0] r_dwell;
    logic          r_loop;
    logic [CW-1:0] r_dwell_cnt;

    logic          w_accept;
    logic          w_step_end;
    logic          w_last_step;
    logic          w_advance;

    assign w_step_end  = (r_dwell_cnt == r_dwell);
    assign w_last_step = (step_idx == r_nsteps);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous terminal step, so no done pulse.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_advance = w_step_end;
                    if (w_step_end && w_last_step && !r_loop) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status flags are flopped from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            dds_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            cfg_ready <= (w_state_nxt == ST_IDLE);
            busy      <= (w_state_nxt == ST_RUN);
            dds_en    <= (w_state_nxt == ST_RUN);
            done      <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f0        <= '0;
            r_step      <= '0;
            r_nsteps    <= '0;
            r_dwell     <= '0;
            r_loop      <= 1'b0;
            r_dwell_cnt <= '0;
            dds_freq    <= '0;
            dds_phase   <= '0;
            step_idx    <= '0;
        end else if (w_accept) begin
            r_f0        <= cfg_f0;
            r_step      <= cfg_step;
            r_nsteps    <= cfg_nsteps;
            r_dwell     <= cfg_dwell;
            r_loop      <= cfg_loop;
            r_dwell_cnt <= '0;
            dds_freq    <= cfg_f0;
            dds_phase   <= cfg_phase;
            step_idx    <= '0;
        end else if (r_state == ST_RUN && !abort) begin
            if (w_advance) begin
                r_dwell_cnt <= '0;
                if (!w_last_step) begin
                    dds_freq <= dds_freq + r_step;
                    step_idx <= step_idx + CW'(1);
                end else if (r_loop) begin
                    dds_freq <= r_f0;
                    step_idx <= '0;
                end
            end else begin
                r_dwell_cnt <= r_dwell_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Purpose  : Randomized scoreboard bench for dds_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;
    localparam int PW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_f0 = '0;
    logic [PW-1:0] cfg_step = '0;
    logic [CW-1:0] cfg_nsteps = '0;
    logic [CW-1:0] cfg_dwell = '0;
    logic [PW-1:0] cfg_phase = '0;
    logic          cfg_loop = 1'b0;
    logic          abort = 1'b0;
    logic          dds_en;
    logic [PW-1:0] dds_freq;
    logic [PW-1:0] dds_phase;
    logic [CW-1:0] step_idx;
    logic          busy;
    logic          done;

    dds_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_f0(cfg_f0), .cfg_step(cfg_step), .cfg_nsteps(cfg_nsteps),
        .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_loop(cfg_loop),
        .abort(abort), .dds_en(dds_en), .dds_freq(dds_freq),
        .dds_phase(dds_phase), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [PW-1:0] freq;
        logic [PW-1:0] phase;
        logic [CW-1:0] idx;
        logic          busy;
        logic          done;
        logic          ready;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          mon_e;
    rec_t          mon_a;
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] m_freq = '0;
    logic [PW-1:0] m_phase = '0;
    logic [CW-1:0] m_idx = '0;

    function automatic rec_t mk(input logic en, input logic bz, input logic dn, input logic rd);
        rec_t r;
        r = '{en: en, freq: m_freq, phase: m_phase, idx: m_idx, busy: bz, done: dn, ready: rd};
        return r;
    endfunction

    // Expected outputs for the cycle following this rising edge.
    task automatic tick(input rec_t e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{en: dds_en, freq: dds_freq, phase: dds_phase, idx: step_idx,
                      busy: busy, done: done, ready: cfg_ready};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs @%0t: actual en=%0b freq=%h phase=%h idx=%0d busy=%0b done=%0b ready=%0b required en=%0b freq=%h phase=%h idx=%0d busy=%0b done=%0b ready=%0b",
                         $time, mon_a.en, mon_a.freq, mon_a.phase, mon_a.idx, mon_a.busy, mon_a.done, mon_a.ready,
                         mon_e.en, mon_e.freq, mon_e.phase, mon_e.idx, mon_e.busy, mon_e.done, mon_e.ready);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            abort = 1'($urandom_range(0, 1));
            tick(mk(1'b0, 1'b0, 1'b0, 1'b1));
        end
        abort = 1'b0;
    endtask

    // stop_at: RUN cycle on which abort (or rst) is raised, -1 for none.
    task automatic sweep(input logic [PW-1:0] f0, input logic [PW-1:0] st,
                         input logic [PW-1:0] ph, input logic [CW-1:0] n,
                         input logic [CW-1:0] d, input logic lp, input int stop_at,
                         input bit use_rst, input bit junk);
        int total;
        int c;
        logic [CW-1:0] k;
        total      = int'(n + 1) * int'(d + 1);
        cfg_f0     = f0;
        cfg_step   = st;
        cfg_phase  = ph;
        cfg_nsteps = n;
        cfg_dwell  = d;
        cfg_loop   = lp;
        cfg_valid  = 1'b1;
        c = 0;
        forever begin
            k       = CW'((c / int'(d + 1)) % int'(n + 1));
            m_idx   = k;
            m_freq  = f0 + st * PW'(k);
            m_phase = ph;
            tick(mk(1'b1, 1'b1, 1'b0, 1'b0));
            cfg_valid = junk;
            if (junk) begin
                cfg_f0     = $urandom;
                cfg_step   = $urandom;
                cfg_phase  = $urandom;
                cfg_nsteps = CW'($urandom);
                cfg_dwell  = CW'($urandom);
                cfg_loop   = 1'($urandom);
            end
            if (c == stop_at) begin
                if (use_rst) begin
                    rst = 1'b1;
                    m_freq = '0;
                    m_phase = '0;
                    m_idx = '0;
                end else begin
                    abort = 1'b1;
                end
                tick(mk(1'b0, 1'b0, 1'b0, 1'b1));
                rst = 1'b0;
                abort = 1'b0;
                cfg_valid = 1'b0;
                return;
            end
            if (!lp && c == total - 1) begin
                tick(mk(1'b0, 1'b0, 1'b1, 1'b0));
                tick(mk(1'b0, 1'b0, 1'b0, 1'b1));
                cfg_valid = 1'b0;
                return;
            end
            c++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, total, stop;
        bit lp;
        rst = 1'b1;
        tick(mk(1'b0, 1'b0, 1'b0, 1'b1));
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: actual cfg_ready=%0b required 1", cfg_ready);
        end
        checks++;
        if (dds_en !== 1'b0) begin
            errors++;
            $display("FAIL reset: actual dds_en=%0b required 0", dds_en);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: actual busy=%0b required 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset: actual done=%0b required 0", done);
        end
        checks++;
        if (dds_freq !== '0) begin
            errors++;
            $display("FAIL reset: actual dds_freq=%h required 0", dds_freq);
        end
        checks++;
        if (dds_phase !== '0) begin
            errors++;
            $display("FAIL reset: actual dds_phase=%h required 0", dds_phase);
        end
        checks++;
        if (step_idx !== '0) begin
            errors++;
            $display("FAIL reset: actual step_idx=%0d required 0", step_idx);
        end
        rst = 1'b0;
        idle_cycles(3);

        sweep(32'd100, 32'd10, 32'h1234, 16'd3, 16'd1, 1'b0, -1, 1'b0, 1'b0);
        idle_cycles(2);
        sweep(32'h7FFF_FFF0, 32'h20, 32'h0, 16'd1, 16'd0, 1'b0, -1, 1'b0, 1'b0);
        idle_cycles(1);
        sweep(32'd5, 32'hFFFF_FFFF, 32'h55, 16'd2, 16'd0, 1'b1, 10, 1'b0, 1'b0);
        idle_cycles(2);
        sweep(32'd77, 32'd3, 32'h9, 16'd0, 16'd4, 1'b0, -1, 1'b0, 1'b1);
        idle_cycles(1);
        sweep(32'd1000, 32'd7, 32'hAA, 16'd2, 16'd1, 1'b0, 5, 1'b0, 1'b1);
        idle_cycles(1);
        sweep(32'd400, 32'd9, 32'hBB, 16'd4, 16'd2, 1'b0, 6, 1'b1, 1'b1);
        idle_cycles(2);

        for (int s = 0; s < 40; s++) begin
            n     = $urandom_range(0, 5);
            d     = $urandom_range(0, 3);
            lp    = 1'($urandom_range(0, 1));
            total = (n + 1) * (d + 1);
            if (lp)
                stop = $urandom_range(0, 30);
            else if ($urandom_range(0, 2) == 0)
                stop = $urandom_range(0, total - 1);
            else
                stop = -1;
            sweep($urandom, $urandom, $urandom, CW'(n), CW'(d), lp, stop,
                  (stop >= 0) && ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: actual %0d pending expectations required 0", exp_q.size());
        end
        checks++;
        if (checks < 12) begin
            errors++;
            $display("FAIL scoreboard: actual %0d checks required at least 12", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PW, default 32, phase/frequency word width matching the DDS.
REQ-002 SHALL have parameter CW, default 16, step-count and dwell-count width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1, sweep request with configuration.
REQ-006 SHALL have port cfg_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port cfg_f0, input, PW, signed start frequency word.
REQ-008 SHALL have port cfg_step, input, PW, signed per-step frequency increment.
REQ-009 SHALL have port cfg_nsteps, input, CW, number of increments after f0.
REQ-010 SHALL have port cfg_dwell, input, CW, extra cycles held per step (step lasts dwell+1 cycles).
REQ-011 SHALL have port cfg_phase, input, PW, signed phase offset for the whole sweep.
REQ-012 SHALL have port cfg_loop, input, 1, 1 = restart from f0 after the last step.
REQ-013 SHALL have port abort, input, 1, stop the running sweep.
REQ-014 SHALL have port dds_en, output, 1, DDS enable.
REQ-015 SHALL have port dds_freq, output, PW, signed DDS frequency word.
REQ-016 SHALL have port dds_phase, output, PW, signed DDS phase offset.
REQ-017 SHALL have port step_idx, output, CW, current step index.
REQ-018 SHALL have ports busy, output, 1, sweep running; done, output, 1, one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; cfg_ready=1 only in IDLE; busy=1 only in RUN.
REQ-020 SHALL accept a request on cfg_valid&cfg_ready, latch all cfg_* fields, and enter RUN next cycle with dds_freq=cfg_f0, dds_phase=cfg_phase, step_idx=0, dwell counter=0.
REQ-021 SHALL drive dds_en=1 in every RUN cycle and 0 in IDLE and DONE; all outputs registered.
REQ-022 SHALL in RUN increment the dwell counter each cycle until it equals latched dwell, then reset it to 0 and advance the step.
REQ-023 SHALL on step advance with step_idx<nsteps: dds_freq<=dds_freq+step (modulo 2^PW, wrap silently), step_idx<=step_idx+1.
REQ-024 SHALL on step advance with step_idx==nsteps: if loop, dds_freq<=f0 and step_idx<=0 staying in RUN; else go to DONE.
REQ-025 SHALL make a non-looping sweep occupy exactly (nsteps+1)*(dwell+1) RUN cycles; nsteps=0 gives f0 only, dwell=0 gives one cycle per step.
REQ-026 SHALL assert done for exactly the single DONE cycle, then return to IDLE; dds_freq, dds_phase, step_idx hold their last values in DONE and IDLE.
REQ-027 SHALL on abort in RUN go to IDLE next cycle without a done pulse; abort in IDLE/DONE is ignored.
REQ-028 SHALL give abort priority over a simultaneous terminal step advance (no done).
REQ-029 SHALL ignore cfg_valid while cfg_ready=0; latched configuration is not altered mid-sweep.

Reset
REQ-030 SHALL on rst force IDLE and clear dds_en, dds_freq, dds_phase, step_idx, busy, done, dwell counter and latched config to 0; cfg_ready=1 from the first cycle after rst deasserts.
REQ-031 SHALL honour rst mid-sweep with the same result, no done pulse.

Verification
REQ-032 f0=100, step=10, nsteps=3, dwell=1, loop=0 -> dds_freq 100,100,110,110,120,120,130,130 with dds_en=1, then done=1 one cycle, dds_en=0, cfg_ready=1.
REQ-033 f0=0x7FFFFFF0, step=0x20, nsteps=1, dwell=0 -> dds_freq 0x7FFFFFF0 then 0x80000010 (wrap), done after 2 RUN cycles.
REQ-034 f0=5, step=-1, nsteps=2, dwell=0, loop=1 -> dds_freq repeats 5,4,3,5,4,3...; done never asserts; abort -> IDLE next cycle, done=0.
REQ-035 nsteps=0, dwell=4 -> dds_freq=f0 for 5 cycles, step_idx=0 throughout, then done.
REQ-036 cfg_valid held high during RUN with different f0 -> ignored; abort on final RUN cycle -> no done; rst mid-sweep -> all outputs 0 next cycle.
